// File: rtl/rv_iopmp_reg_pkg.sv
// Shared types and helpers for the IOPMP register-bus front-end.
// Structs are sized by the package-level widths; modules with other widths use their own signals.
package rv_iopmp_reg_pkg;

    localparam int REG_AW = 12;
    localparam int REG_DW = 32;

    typedef struct packed {
        logic                valid;
        logic                write;
        logic [REG_AW-1:0]   addr;
        logic [REG_DW-1:0]   wdata;
        logic [REG_DW/8-1:0] be;
    } reg_req_t;

    typedef struct packed {
        logic              valid;
        logic [REG_DW-1:0] rdata;
        logic              error;
    } reg_rsp_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } resp_state_e;

    // Number of byte-offset bits inside one data word.
    function automatic int off_width(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/rv_iopmp_reg_addr_dec.sv
// Combinational byte-address decoder: one-hot word select plus mapped/aligned flags.
module rv_iopmp_reg_addr_dec
    import rv_iopmp_reg_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int NUM_REGS = 16
) (
    input  logic [AW-1:0]       addr,
    output logic [NUM_REGS-1:0] sel_onehot,
    output logic                mapped,
    output logic                aligned
);

    localparam int OFFW = off_width(DW);
    localparam int IW   = AW - OFFW;

    logic [IW-1:0] word_idx;

    assign word_idx = addr[AW-1:OFFW];
    assign aligned  = (addr[OFFW-1:0] == '0);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign sel_onehot[gi] = (word_idx == IW'(gi));
        end
    endgenerate

    // An index beyond the register file selects nothing, so "mapped" falls out of the one-hot.
    assign mapped = |sel_onehot;

endmodule

// File: rtl/rv_iopmp_reg_resp.sv
// Register-bus responder: decodes one request per cycle, drives field-arbiter strobes,
// and returns a single-entry buffered response with an error flag.
module rv_iopmp_reg_resp
    import rv_iopmp_reg_pkg::*;
#(
    parameter int AW           = 12,
    parameter int DW           = 32,
    parameter int NUM_REGS     = 16,
    parameter bit ERR_UNMAPPED = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [AW-1:0]          req_addr_i,
    input  logic [DW-1:0]          req_wdata_i,
    input  logic [DW/8-1:0]        req_be_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DW-1:0]          rsp_rdata_o,
    output logic                   rsp_error_o,
    output logic [NUM_REGS-1:0]    reg_we_o,
    output logic [NUM_REGS-1:0]    reg_re_o,
    output logic [DW-1:0]          reg_wd_o,
    input  logic [NUM_REGS*DW-1:0] reg_q_i,
    input  logic [NUM_REGS-1:0]    reg_lock_i
);

    resp_state_e         state_reg;
    logic [DW-1:0]       rdata_reg;
    logic                error_reg;

    logic [NUM_REGS-1:0] sel_onehot;
    logic                mapped;
    logic                aligned;
    logic                accept;
    logic                bad_access;
    logic                locked;
    logic                good_read;
    logic [DW-1:0]       q_sel [NUM_REGS];
    logic [DW-1:0]       rd_word;

    rv_iopmp_reg_addr_dec #(
        .AW       (AW),
        .DW       (DW),
        .NUM_REGS (NUM_REGS)
    ) u_addr_dec (
        .addr       (req_addr_i),
        .sel_onehot (sel_onehot),
        .mapped     (mapped),
        .aligned    (aligned)
    );

    // The buffer may be refilled in the same cycle it is drained.
    assign req_ready_o = !rst_i && ((state_reg == EMPTY) || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    // Fields are word-atomic, so partial writes are rejected like bad addresses.
    assign bad_access = !mapped || !aligned || (req_write_i && (req_be_i != '1));
    assign locked     = |(sel_onehot & reg_lock_i);
    assign good_read  = accept && !req_write_i && !bad_access;

    assign reg_we_o = (accept && req_write_i && !bad_access && !locked) ? sel_onehot : '0;
    assign reg_re_o = good_read ? sel_onehot : '0;
    assign reg_wd_o = req_wdata_i;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_qmux
            assign q_sel[gi] = sel_onehot[gi] ? reg_q_i[gi*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_word = rd_word | q_sel[i];
        end
    end

    // Read data is captured at the accept edge, i.e. before any read-clear lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= EMPTY;
            rdata_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg <= FULL;
                        rdata_reg <= good_read ? rd_word : '0;
                        error_reg <= ERR_UNMAPPED && bad_access;
                    end
                end
                FULL: begin
                    if (accept) begin
                        state_reg <= FULL;
                        rdata_reg <= good_read ? rd_word : '0;
                        error_reg <= ERR_UNMAPPED && bad_access;
                    end else if (rsp_ready_i) begin
                        state_reg <= EMPTY;
                        rdata_reg <= '0;
                        error_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    rdata_reg <= '0;
                    error_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o = (state_reg == FULL);
    assign rsp_rdata_o = rdata_reg;
    assign rsp_error_o = error_reg;

endmodule

// File: tb/tb_rv_iopmp_reg_resp.sv
// Directed bench for rv_iopmp_reg_resp: strobes, responses, errors, back-pressure, RC order, reset.
module tb_rv_iopmp_reg_resp;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;

    logic           clk_i;
    logic           rst_i;
    logic           req_valid_i;
    logic           req_ready_o;
    logic           req_write_i;
    logic [AW-1:0]  req_addr_i;
    logic [DW-1:0]  req_wdata_i;
    logic [DW/8-1:0] req_be_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [DW-1:0]  rsp_rdata_o;
    logic           rsp_error_o;
    logic [NR-1:0]  reg_we_o;
    logic [NR-1:0]  reg_re_o;
    logic [DW-1:0]  reg_wd_o;
    logic [NR*DW-1:0] reg_q_i;
    logic [NR-1:0]  reg_lock_i;

    logic [DW-1:0]  q_arr [NR];
    logic           rc_en;
    logic           rc_load;
    logic [DW-1:0]  rc_q1;

    int checks;
    int errors;

    rv_iopmp_reg_resp #(
        .AW(AW), .DW(DW), .NUM_REGS(NR), .ERR_UNMAPPED(1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_wd_o    (reg_wd_o),
        .reg_q_i     (reg_q_i),
        .reg_lock_i  (reg_lock_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Read-clear model for register 1: cleared by the software read strobe at the edge.
    always @(posedge clk_i) begin
        if (rc_load)
            rc_q1 <= 32'h0000_0001;
        else if (reg_re_o[1])
            rc_q1 <= '0;
    end

    always_comb begin
        reg_q_i = '0;
        for (int i = 0; i < NR; i++) begin
            reg_q_i[i*DW +: DW] = (i == 1 && rc_en) ? rc_q1 : q_arr[i];
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_be_i    = be;
        #1;
    endtask

    task automatic idle_req();
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata_o); end
        checks++; if (rsp_error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", rsp_error_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", req_ready_o); end
        $display("reset: valid=%b ready=%b", rsp_valid_o, req_ready_o);
    endtask

    task automatic test_read();
        rsp_ready_i = 1'b1;
        drive_req(1'b0, 12'h008, 32'h0, 4'hF);
        checks++; if (reg_re_o !== 16'h0004) begin errors++; $display("FAIL read_re got %h exp 0004", reg_re_o); end
        checks++; if (reg_we_o !== 16'h0000) begin errors++; $display("FAIL read_we got %h exp 0000", reg_we_o); end
        next_cycle();
        idle_req();
        #1;
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL read_valid got %b exp 1", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", rsp_rdata_o); end
        checks++; if (rsp_error_o !== 1'b0) begin errors++; $display("FAIL read_error got %b exp 0", rsp_error_o); end
        $display("read reg2: rdata=%h err=%b", rsp_rdata_o, rsp_error_o);
        next_cycle();
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL read_drain got %b exp 0", rsp_valid_o); end
    endtask

    task automatic test_write();
        for (int k = 0; k < 2; k++) begin
            reg_lock_i = (k == 1) ? 16'h0008 : 16'h0000;
            drive_req(1'b1, 12'h00C, 32'h0000_00A5, 4'hF);
            checks++; if (reg_we_o !== ((k == 1) ? 16'h0000 : 16'h0008)) begin errors++; $display("FAIL write_we lock=%0d got %h", k, reg_we_o); end
            checks++; if (reg_wd_o !== 32'h0000_00A5) begin errors++; $display("FAIL write_wd got %h exp 000000a5", reg_wd_o); end
            checks++; if (reg_re_o !== 16'h0000) begin errors++; $display("FAIL write_re got %h exp 0000", reg_re_o); end
            next_cycle();
            idle_req();
            #1;
            checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0 || rsp_error_o !== 1'b0) begin
                errors++; $display("FAIL write_rsp lock=%0d got v=%b d=%h e=%b exp v=1 d=0 e=0", k, rsp_valid_o, rsp_rdata_o, rsp_error_o);
            end
            $display("write reg3 lock=%0d: we=%h err=%b", k, reg_we_o, rsp_error_o);
            next_cycle();
        end
        reg_lock_i = '0;
    endtask

    task automatic test_errors();
        logic        wr_t   [3] = '{1'b0, 1'b0, 1'b1};
        logic [11:0] addr_t [3] = '{12'h006, 12'h040, 12'h00C};
        logic [3:0]  be_t   [3] = '{4'hF, 4'hF, 4'h3};
        for (int k = 0; k < 3; k++) begin
            drive_req(wr_t[k], addr_t[k], 32'h1234_5678, be_t[k]);
            checks++; if (reg_we_o !== 16'h0 || reg_re_o !== 16'h0) begin
                errors++; $display("FAIL err_strobe case=%0d got we=%h re=%h exp 0", k, reg_we_o, reg_re_o);
            end
            next_cycle();
            idle_req();
            #1;
            checks++; if (rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
                errors++; $display("FAIL err_rsp case=%0d got v=%b e=%b d=%h exp v=1 e=1 d=0", k, rsp_valid_o, rsp_error_o, rsp_rdata_o);
            end
            $display("error case %0d addr=%h: err=%b", k, addr_t[k], rsp_error_o);
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready_i = 1'b0;
        drive_req(1'b0, 12'h008, 32'h0, 4'hF);
        next_cycle();
        drive_req(1'b0, 12'h000, 32'h0, 4'hF);
        for (int c = 0; c < 5; c++) begin
            checks++; if (req_ready_o !== 1'b0 || reg_re_o !== 16'h0) begin
                errors++; $display("FAIL bp_stall cyc=%0d got ready=%b re=%h exp 0/0", c, req_ready_o, reg_re_o);
            end
            checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF || rsp_error_o !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b exp 1/deadbeef/0", c, rsp_valid_o, rsp_rdata_o, rsp_error_o);
            end
            next_cycle();
        end
        rsp_ready_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 1'b1 || reg_re_o !== 16'h0001) begin
            errors++; $display("FAIL bp_release got ready=%b re=%h exp 1/0001", req_ready_o, reg_re_o);
        end
        next_cycle();
        idle_req();
        #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1111_1111) begin
            errors++; $display("FAIL bp_second got v=%b d=%h exp 1/11111111", rsp_valid_o, rsp_rdata_o);
        end
        $display("backpressure: second rdata=%h", rsp_rdata_o);
        next_cycle();
    endtask

    task automatic test_rc_order();
        rc_en   = 1'b1;
        rc_load = 1'b1;
        next_cycle();
        rc_load = 1'b0;
        drive_req(1'b0, 12'h004, 32'h0, 4'hF);
        next_cycle();
        #1;
        checks++; if (rsp_rdata_o !== 32'h1) begin errors++; $display("FAIL rc_first got %h exp 00000001", rsp_rdata_o); end
        checks++; if (reg_re_o !== 16'h0002) begin errors++; $display("FAIL rc_b2b_re got %h exp 0002", reg_re_o); end
        next_cycle();
        idle_req();
        #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
            errors++; $display("FAIL rc_second got v=%b d=%h exp 1/0", rsp_valid_o, rsp_rdata_o);
        end
        $display("rc order: second rdata=%h", rsp_rdata_o);
        next_cycle();
        rc_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        rsp_ready_i = 1'b0;
        drive_req(1'b0, 12'h008, 32'h0, 4'hF);
        next_cycle();
        drive_req(1'b1, 12'h00C, 32'h55, 4'hF);
        #1;
        rst_i = 1'b1;
        #1;
        checks++; if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_error_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_rsp got v=%b d=%h e=%b exp 0/0/0", rsp_valid_o, rsp_rdata_o, rsp_error_o);
        end
        checks++; if (req_ready_o !== 1'b0 || reg_we_o !== 16'h0 || reg_re_o !== 16'h0) begin
            errors++; $display("FAIL mid_reset_strobe got ready=%b we=%h re=%h exp 0", req_ready_o, reg_we_o, reg_re_o);
        end
        next_cycle();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        drive_req(1'b0, 12'h008, 32'h0, 4'hF);
        next_cycle();
        idle_req();
        #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL after_reset_read got v=%b d=%h exp 1/deadbeef", rsp_valid_o, rsp_rdata_o);
        end
        $display("mid reset: recovered rdata=%h", rsp_rdata_o);
        next_cycle();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_i       = 1'b1;
        rsp_ready_i = 1'b0;
        reg_lock_i  = '0;
        rc_en       = 1'b0;
        rc_load     = 1'b0;
        idle_req();
        for (int i = 0; i < NR; i++) q_arr[i] = 32'hA000_0000 | 32'(i);
        q_arr[0] = 32'h1111_1111;
        q_arr[2] = 32'hDEAD_BEEF;

        test_reset();
        test_read();
        test_write();
        test_errors();
        test_backpressure();
        test_rc_order();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
